// File: rtl/img_mem_writer.sv
// img_mem_writer: loads one image frame from a valid/ready pixel stream into
// the convolution engine's image memory. Addresses are row*IMG_W+col per
// channel plane, and every write-side output is registered.
module img_mem_writer #(
    parameter int unsigned IMG_W    = 14,
    parameter int unsigned IMG_H    = 14,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic        [ADDR_W-1:0] wr_addr,
    output logic        [4:0]        wr_ch,
    output logic signed [DATA_W-1:0] wr_data,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CH_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic        [COL_W-1:0]   r_col;
    logic        [ROW_W-1:0]   r_row;
    logic        [CH_W-1:0]    r_ch;
    logic                      r_in_ready;
    logic                      r_wr_en;
    logic        [ADDR_W-1:0]  r_wr_addr;
    logic        [CH_W-1:0]    r_wr_ch;
    logic signed [DATA_W-1:0]  r_wr_data;
    logic                      r_busy;
    logic                      r_frame_done;

    logic                      w_xfer;
    logic                      w_col_last;
    logic                      w_row_last;
    logic                      w_ch_last;
    logic                      w_frame_last;
    logic        [COL_W-1:0]   w_col_nxt;
    logic        [ROW_W-1:0]   w_row_nxt;
    logic        [CH_W-1:0]    w_ch_nxt;
    logic        [ADDR_W-1:0]  w_addr;

    // Handshake and raster-position decode for the pixel being accepted
    assign w_xfer       = in_valid & r_in_ready;
    assign w_col_last   = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last   = (r_row == ROW_W'(IMG_H - 1));
    assign w_ch_last    = (r_ch == CH_W'(CHANNELS - 1));
    assign w_frame_last = w_col_last & w_row_last & w_ch_last;

    // Column-fastest, then row, then channel plane
    assign w_col_nxt = w_col_last ? '0 : r_col + COL_W'(1);
    assign w_row_nxt = w_col_last ? (w_row_last ? '0 : r_row + ROW_W'(1)) : r_row;
    assign w_ch_nxt  = (w_col_last && w_row_last) ? r_ch + CH_W'(1) : r_ch;

    // Unsigned address in ADDR_W bits, matching the engine's read addressing
    assign w_addr = ADDR_W'(ADDR_W'(r_row) * ADDR_W'(IMG_W)) + ADDR_W'(r_col);

    // Frame-load FSM with counters and registered write/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_ch         <= '0;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_ch      <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_ch       <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // An accepted pixel is always written, even alongside abort
                    if (w_xfer) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= in_data;
                        r_wr_addr <= w_addr;
                        r_wr_ch   <= r_ch;
                        r_col     <= w_col_nxt;
                        r_row     <= w_row_nxt;
                        r_ch      <= w_ch_nxt;
                    end
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_ch       <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_xfer && w_frame_last) begin
                        r_state      <= S_DONE;
                        r_in_ready   <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_ch      = r_wr_ch;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_img_mem_writer.sv
// Directed bench for img_mem_writer: single-channel and two-channel instances.
module tb_img_mem_writer;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int          PLANE = 196;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 start2 = 1'b0;
    logic                 abort = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 sel = 1'b0;

    logic                 in_ready1, wr_en1, busy1, frame_done1;
    logic        [AW-1:0] wr_addr1;
    logic        [4:0]    wr_ch1;
    logic signed [DW-1:0] wr_data1;
    logic                 in_ready2, wr_en2, busy2, frame_done2;
    logic        [AW-1:0] wr_addr2;
    logic        [4:0]    wr_ch2;
    logic signed [DW-1:0] wr_data2;

    logic                 m_in_ready, m_wr_en, m_busy, m_frame_done;
    logic        [AW-1:0] m_wr_addr;
    logic        [4:0]    m_wr_ch;
    logic signed [DW-1:0] m_wr_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    img_mem_writer u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_ch(wr_ch1), .wr_data(wr_data1),
        .busy(busy1), .frame_done(frame_done1)
    );

    img_mem_writer #(.CHANNELS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_ch(wr_ch2), .wr_data(wr_data2),
        .busy(busy2), .frame_done(frame_done2)
    );

    assign m_in_ready   = sel ? in_ready2   : in_ready1;
    assign m_wr_en      = sel ? wr_en2      : wr_en1;
    assign m_busy       = sel ? busy2       : busy1;
    assign m_frame_done = sel ? frame_done2 : frame_done1;
    assign m_wr_addr    = sel ? wr_addr2    : wr_addr1;
    assign m_wr_ch      = sel ? wr_ch2      : wr_ch1;
    assign m_wr_data    = sel ? wr_data2    : wr_data1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulse start (or hold it) for the selected instance; returns at the first LOAD negedge
    task automatic do_start(input bit hold);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        if (!hold) begin
            start  = 1'b0;
            start2 = 1'b0;
        end
        chk("busy_after_start", m_busy, 1);
    endtask

    // Drive n pixels beginning at frame index first; mode 0 back-to-back, mode 1 valid 1,0,0
    task automatic run_xfers(input int n, input int first, input int frame_px,
                             input int mode, input bit abort_last);
        int  sent;
        int  cyc;
        int  idx;
        bit  v;
        sent = 0;
        cyc  = 0;
        while (sent < n) begin
            v   = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            idx = first + sent;
            chk($sformatf("in_ready[%0d]", idx), m_in_ready, 1);
            in_valid = v;
            in_data  = DW'(idx % 128);
            abort    = abort_last && v && (sent == n - 1);
            @(negedge clk);
            if (v) begin
                chk($sformatf("wr_en[%0d]", idx), m_wr_en, 1);
                chk($sformatf("wr_addr[%0d]", idx), m_wr_addr, idx % PLANE);
                chk($sformatf("wr_ch[%0d]", idx), m_wr_ch, idx / PLANE);
                chk($sformatf("wr_data[%0d]", idx), m_wr_data, idx % 128);
                if (idx != frame_px - 1 && !abort)
                    chk($sformatf("frame_done_early[%0d]", idx), m_frame_done, 0);
                sent++;
            end else begin
                chk($sformatf("stall_wr_en[%0d]", idx), m_wr_en, 0);
                if (idx > 0)
                    chk($sformatf("stall_addr_hold[%0d]", idx), m_wr_addr, (idx - 1) % PLANE);
            end
            cyc++;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_in_ready", m_in_ready, 0);
        chk("rst_wr_en", m_wr_en, 0);
        chk("rst_wr_addr", m_wr_addr, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_frame_done", m_frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", m_in_ready, 0);

        // Full back-to-back frame
        do_start(1'b0);
        run_xfers(PLANE, 0, PLANE, 0, 1'b0);
        chk("b2b_frame_done", m_frame_done, 1);
        chk("b2b_busy_done", m_busy, 0);
        chk("b2b_in_ready_done", m_in_ready, 0);
        @(negedge clk);
        chk("b2b_frame_done_one", m_frame_done, 0);
        chk("b2b_wr_en_after", m_wr_en, 0);

        // Stalled stream
        do_start(1'b0);
        run_xfers(PLANE, 0, PLANE, 1, 1'b0);
        chk("stall_frame_done", m_frame_done, 1);
        @(negedge clk);

        // Abort after 50 transfers, then a clean reload from address 0
        do_start(1'b0);
        run_xfers(50, 0, PLANE, 0, 1'b1);
        chk("abort_busy", m_busy, 0);
        chk("abort_in_ready", m_in_ready, 0);
        chk("abort_frame_done", m_frame_done, 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", m_frame_done, 0);
        end
        do_start(1'b0);
        run_xfers(PLANE, 0, PLANE, 0, 1'b0);
        chk("reload_frame_done", m_frame_done, 1);
        @(negedge clk);

        // Two channel planes
        sel = 1'b1;
        do_start(1'b0);
        run_xfers(2 * PLANE, 0, 2 * PLANE, 0, 1'b0);
        chk("ch2_frame_done", m_frame_done, 1);
        @(negedge clk);
        chk("ch2_frame_done_one", m_frame_done, 0);
        sel = 1'b0;

        // Async reset mid-frame, between clock edges
        do_start(1'b0);
        run_xfers(100, 0, PLANE, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", m_in_ready, 0);
        chk("arst_wr_en", m_wr_en, 0);
        chk("arst_wr_addr", m_wr_addr, 0);
        chk("arst_wr_ch", m_wr_ch, 0);
        chk("arst_wr_data", m_wr_data, 0);
        chk("arst_busy", m_busy, 0);
        chk("arst_frame_done", m_frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("arst_idle_ready", m_in_ready, 0);
            chk("arst_idle_done", m_frame_done, 0);
        end
        do_start(1'b0);
        run_xfers(3, 0, PLANE, 0, 1'b1);
        chk("arst_restart_busy", m_busy, 0);

        // start held through LOAD and DONE
        do_start(1'b1);
        run_xfers(PLANE, 0, PLANE, 0, 1'b0);
        chk("hold_frame_done", m_frame_done, 1);
        @(negedge clk);
        chk("hold_idle_busy", m_busy, 0);
        chk("hold_idle_ready", m_in_ready, 0);
        chk("hold_idle_done", m_frame_done, 0);
        @(negedge clk);
        chk("hold_reenter_busy", m_busy, 1);
        chk("hold_reenter_ready", m_in_ready, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("hold_exit_busy", m_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
